// File: rtl/slt_iterative.sv
// slt_iterative: multi-cycle signed/unsigned less-than and equality comparator.
// Each RUN cycle takes one W-bit chunk of the operands, starting with the least
// significant chunk. The chunk goes through a subtract slice (a + ~b + carry)
// whose carry is held in a register between cycles. A full compare therefore
// takes N/W cycles.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   synchronous reset, active-high
//   i_valid  in   request valid
//   o_ready  out  request accepted when high (IDLE only)
//   a, b     in   N-bit operands, sampled on accept
//   op       in   00 SLT, 01 SLTU, 10 EQ, 11 NE, sampled on accept
//   o_valid  out  result valid (DONE only)
//   i_ready  in   consumer takes the result
//   out      out  compare result, held until the next result or reset
module slt_iterative #(
  parameter int unsigned N = 32,
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   op,
  output logic         o_valid,
  input  logic         i_ready,
  output logic         out
);

  localparam int unsigned CHUNKS = N / W;
  localparam int unsigned IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  localparam logic [1:0] OP_SLT  = 2'b00;
  localparam logic [1:0] OP_SLTU = 2'b01;
  localparam logic [1:0] OP_EQ   = 2'b10;
  localparam logic [1:0] OP_NE   = 2'b11;

  // Parameter legality is checked at elaboration time.
  if ((N % W) != 0) begin : g_bad_w
    $error("slt_iterative: N (%0d) must be a multiple of W (%0d)", N, W);
  end
  if (N < 2) begin : g_bad_n
    $error("slt_iterative: N (%0d) must be at least 2", N);
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // State and datapath registers
  state_t           r_state;
  logic [N-1:0]     r_a;
  logic [N-1:0]     r_b;
  logic             r_a_sign;
  logic             r_b_sign;
  logic [1:0]       r_op;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic             r_zero;
  logic             r_out;
  logic             r_ready;
  logic             r_valid;

  // Next-state values
  state_t           w_state_nx;
  logic [N-1:0]     w_a_nx;
  logic [N-1:0]     w_b_nx;
  logic             w_a_sign_nx;
  logic             w_b_sign_nx;
  logic [1:0]       w_op_nx;
  logic [IDX_W-1:0] w_idx_nx;
  logic             w_carry_nx;
  logic             w_zero_nx;
  logic             w_out_nx;

  // Subtract slice on the current chunk. The operand registers shift right by W
  // each cycle, so the current chunk is always in the low W bits.
  logic [W:0]       w_sum;
  logic [W-1:0]     w_d;
  logic             w_c;
  logic             w_zero_upd;
  logic             w_last;

  assign w_sum      = {1'b0, r_a[W-1:0]} + {1'b0, ~r_b[W-1:0]} + (W+1)'(r_carry);
  assign w_d        = w_sum[W-1:0];
  assign w_c        = w_sum[W];
  assign w_zero_upd = r_zero & (w_d == '0);
  assign w_last     = (r_idx == IDX_W'(CHUNKS - 1));

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_a_sign <= 1'b0;
      r_b_sign <= 1'b0;
      r_op     <= OP_SLT;
      r_idx    <= '0;
      r_carry  <= 1'b1;
      r_zero   <= 1'b1;
      r_out    <= 1'b0;
      r_ready  <= 1'b1;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_a      <= w_a_nx;
      r_b      <= w_b_nx;
      r_a_sign <= w_a_sign_nx;
      r_b_sign <= w_b_sign_nx;
      r_op     <= w_op_nx;
      r_idx    <= w_idx_nx;
      r_carry  <= w_carry_nx;
      r_zero   <= w_zero_nx;
      r_out    <= w_out_nx;
      r_ready  <= (w_state_nx == S_IDLE);
      r_valid  <= (w_state_nx == S_DONE);
    end
  end

  // Next-state and datapath update logic
  always_comb begin
    w_state_nx  = r_state;
    w_a_nx      = r_a;
    w_b_nx      = r_b;
    w_a_sign_nx = r_a_sign;
    w_b_sign_nx = r_b_sign;
    w_op_nx     = r_op;
    w_idx_nx    = r_idx;
    w_carry_nx  = r_carry;
    w_zero_nx   = r_zero;
    w_out_nx    = r_out;

    unique case (r_state)
      S_IDLE: begin
        if (i_valid && r_ready) begin
          w_a_nx      = a;
          w_b_nx      = b;
          w_a_sign_nx = a[N-1];
          w_b_sign_nx = b[N-1];
          w_op_nx     = op;
          w_idx_nx    = '0;
          w_carry_nx  = 1'b1;
          w_zero_nx   = 1'b1;
          w_state_nx  = S_RUN;
        end
      end

      S_RUN: begin
        w_a_nx     = N'(r_a >> W);
        w_b_nx     = N'(r_b >> W);
        w_carry_nx = w_c;
        w_zero_nx  = w_zero_upd;
        w_idx_nx   = r_idx + IDX_W'(1);
        if (w_last) begin
          unique case (r_op)
            // On a sign mismatch the negative operand is the smaller one.
            // With equal signs the difference cannot overflow, so its sign
            // bit gives the answer.
            OP_SLT:  w_out_nx = (r_a_sign != r_b_sign) ? r_a_sign : w_d[W-1];
            OP_SLTU: w_out_nx = ~w_c;
            OP_EQ:   w_out_nx = w_zero_upd;
            OP_NE:   w_out_nx = ~w_zero_upd;
            default: w_out_nx = 1'b0;
          endcase
          w_state_nx = S_DONE;
        end
      end

      S_DONE: begin
        if (i_ready) begin
          w_state_nx = S_IDLE;
        end
      end

      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  assign o_ready = r_ready;
  assign o_valid = r_valid;
  assign out     = r_out;

endmodule

// File: tb/tb_slt_iterative.sv
// Directed testbench for slt_iterative with N=32 and W=8.
module tb_slt_iterative;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  op;
  logic        o_valid;
  logic        i_ready;
  logic        out;

  int n_pass;
  int n_total;

  localparam logic [1:0] OP_SLT  = 2'b00;
  localparam logic [1:0] OP_SLTU = 2'b01;
  localparam logic [1:0] OP_EQ   = 2'b10;
  localparam logic [1:0] OP_NE   = 2'b11;

  slt_iterative #(.N(32), .W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .a       (a),
    .b       (b),
    .op      (op),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .out     (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Move one clock edge forward and sample 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Poll for o_valid, giving up after a fixed number of cycles. Returns the
  // number of edges that passed.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!o_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  // Run one request with immediate result acceptance and check the result.
  task automatic do_op(input string tag, input logic [1:0] op_i,
                       input logic [31:0] a_i, input logic [31:0] b_i,
                       input logic exp);
    int lat;
    chk({tag, "_ready_before"}, 32'(o_ready), 32'd1);
    a = a_i; b = b_i; op = op_i; i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom);
    chk({tag, "_ready_busy"}, 32'(o_ready), 32'd0);
    wait_valid(lat);
    chk({tag, "_latency"}, 32'(lat), 32'd4);
    chk({tag, "_out"}, 32'(out), 32'(exp));
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    chk({tag, "_valid_after"}, 32'(o_valid), 32'd0);
    chk({tag, "_ready_after"}, 32'(o_ready), 32'd1);
    chk({tag, "_out_hold"}, 32'(out), 32'(exp));
  endtask

  initial begin
    int lat;
    n_pass = 0; n_total = 0;
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
    a = '0; b = '0; op = '0;
    step();
    step();
    rst = 1'b0;
    chk("reset_ready", 32'(o_ready), 32'd1);
    chk("reset_valid", 32'(o_valid), 32'd0);
    chk("reset_out",   32'(out),     32'd0);

    // Main function vectors
    do_op("slt_neg1_1",   OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    do_op("sltu_max_1",   OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    do_op("sltu_1_max",   OP_SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1);
    do_op("slt_ovf_pos",  OP_SLT,  32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
    do_op("slt_ovf_neg",  OP_SLT,  32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
    do_op("eq_same",      OP_EQ,   32'h1234_5678, 32'h1234_5678, 1'b1);
    do_op("eq_diff",      OP_EQ,   32'h1234_5679, 32'h1234_5678, 1'b0);
    do_op("ne_diff",      OP_NE,   32'h1234_5679, 32'h1234_5678, 1'b1);
    do_op("ne_same",      OP_NE,   32'hA5A5_0000, 32'hA5A5_0000, 1'b0);
    do_op("sltu_equal",   OP_SLTU, 32'h0000_0100, 32'h0000_0100, 1'b0);
    do_op("slt_hi_chunk", OP_SLT,  32'h0100_0000, 32'h00FF_FFFF, 1'b0);

    // Backpressure: the result is held, and a new request waits.
    a = 32'h7FFF_FFFF; b = 32'h8000_0000; op = OP_SLT; i_valid = 1'b1;
    step();
    a = 32'h0000_0001; b = 32'hFFFF_FFFF; op = OP_SLTU;
    wait_valid(lat);
    chk("bp_latency", 32'(lat), 32'd4);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid_held", 32'(o_valid), 32'd1);
      chk("bp_out_held",   32'(out),     32'd0);
      chk("bp_ready_low",  32'(o_ready), 32'd0);
      step();
    end
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    chk("bp_hs_valid", 32'(o_valid), 32'd0);
    chk("bp_hs_ready", 32'(o_ready), 32'd1);
    step();
    i_valid = 1'b0;
    chk("bp_new_accept", 32'(o_ready), 32'd0);
    wait_valid(lat);
    chk("bp_new_latency", 32'(lat), 32'd4);
    chk("bp_new_out",     32'(out), 32'd1);
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    chk("bp_new_done", 32'(o_valid), 32'd0);

    // Reset in the middle of RUN, when idx is 2
    a = 32'hFFFF_FFFF; b = 32'h0000_0001; op = OP_SLT; i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_valid", 32'(o_valid), 32'd0);
    chk("abort_ready", 32'(o_ready), 32'd1);
    chk("abort_out",   32'(out),     32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("abort_no_result", 32'(o_valid), 32'd0);
    end
    do_op("slt_m5_m3", OP_SLT, 32'hFFFF_FFFB, 32'hFFFF_FFFD, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
